// File: rtl/ipu_resize_pool.sv
// ipu_resize_pool
//   Streaming binary-image downscaler. A raster-order 1-bit image of
//   IN_W x IN_H pixels is mapped onto OUT_W x OUT_H cells using
//   cell = floor(pos * OUT / IN). Set pixels are counted per cell.
//   Each cell emits 1 when its count is >= THRESHOLD. Output is produced
//   one band (one output line) at a time.
//
// Ports
//   CLK               clock, rising edge
//   RST               synchronous reset, active-high
//   PIX_VALID         input pixel strobe (gaps allowed)
//   PIX               binary pixel value
//   SOF               start of frame, qualified by PIX_VALID
//   THRESHOLD         count threshold, held for a frame
//   OUT_VALID         output bit strobe, OUT_W-cycle bursts
//   OUT_BIT           pooled cell value
//   OUT_LAST_IN_LINE  marks cell OUT_W-1 of an output line
//   OUT_LAST_PIX      marks the last cell of the frame
//   FRAME_ERR         sticky; SOF seen away from position (0,0)
//   CELL_COUNT        saturated cell count, aligned with OUT_BIT
//                     (present only when IPU_RESIZE_POPCNT_OUT_EN is defined)
//
// Build option
//   IPU_RESIZE_POPCNT_OUT_EN : adds CELL_COUNT and the per-cell count shadow.

module ipu_resize_pool #(
    parameter int IN_W  = 320,
    parameter int IN_H  = 240,
    parameter int OUT_W = 64,
    parameter int OUT_H = 64,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PIX_VALID,
    input  logic             PIX,
    input  logic             SOF,
    input  logic [CNT_W-1:0] THRESHOLD,
    output logic             OUT_VALID,
    output logic             OUT_BIT,
    output logic             OUT_LAST_IN_LINE,
    output logic             OUT_LAST_PIX,
`ifdef IPU_RESIZE_POPCNT_OUT_EN
    output logic [CNT_W-1:0] CELL_COUNT,
`endif
    output logic             FRAME_ERR
);

    localparam int XW  = $clog2(IN_W + 1);
    localparam int YW  = $clog2(IN_H + 1);
    localparam int EXW = $clog2(2 * IN_W);
    localparam int EYW = $clog2(2 * IN_H);
    localparam int CXW = $clog2(OUT_W + 1);
    localparam int CYW = $clog2(OUT_H + 1);
    localparam int IW  = $clog2(OUT_W + 1);

    typedef enum logic {IDLE, EMIT} state_t;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic inc);
        if (inc && (v != {CNT_W{1'b1}}))
            return v + CNT_W'(1);
        else
            return v;
    endfunction

    // Position tracking and per-cell accumulators (stage p0)
    logic [XW-1:0]    x_p0;
    logic [YW-1:0]    y_p0;
    logic [EXW-1:0]   ex_p0;
    logic [EYW-1:0]   ey_p0;
    logic [CXW-1:0]   cx_p0;
    logic [CYW-1:0]   cy_p0;
    logic [CNT_W-1:0] acc_p0 [OUT_W];

    // Effective position for the current pixel (after a possible SOF restart)
    logic             restart;
    logic [XW-1:0]    x_e;
    logic [YW-1:0]    y_e;
    logic [EXW-1:0]   ex_e;
    logic [EYW-1:0]   ey_e;
    logic [CXW-1:0]   cx_e;
    logic [CYW-1:0]   cy_e;
    logic [EXW-1:0]   ex_sum;
    logic [EYW-1:0]   ey_sum;
    logic             col_step;
    logic             row_step;
    logic             line_end;
    logic             last_line;
    logic             band_end;
    logic [CNT_W-1:0] cnt_now [OUT_W];
    logic [OUT_W-1:0] cmp;

    // SOF anywhere but (0,0) restarts the frame; this pixel becomes (0,0).
    assign restart = PIX_VALID && SOF && ((x_p0 != '0) || (y_p0 != '0));

    always_comb begin
        x_e  = restart ? '0 : x_p0;
        y_e  = restart ? '0 : y_p0;
        ex_e = restart ? '0 : ex_p0;
        ey_e = restart ? '0 : ey_p0;
        cx_e = restart ? '0 : cx_p0;
        cy_e = restart ? '0 : cy_p0;

        ex_sum   = ex_e + EXW'(OUT_W);
        ey_sum   = ey_e + EYW'(OUT_H);
        col_step = (ex_sum >= EXW'(IN_W));
        row_step = (ey_sum >= EYW'(IN_H));

        line_end  = PIX_VALID && (x_e == XW'(IN_W - 1));
        last_line = (y_e == YW'(IN_H - 1));
        band_end  = line_end && (row_step || last_line);

        // Compare includes the current pixel, so nothing is lost at band end.
        for (int i = 0; i < OUT_W; i++) begin
            cnt_now[i] = sat_inc(restart ? '0 : acc_p0[i],
                                 PIX_VALID && PIX && (cx_e == CXW'(i)));
            cmp[i]     = (cnt_now[i] >= THRESHOLD);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            x_p0      <= '0;
            y_p0      <= '0;
            ex_p0     <= '0;
            ey_p0     <= '0;
            cx_p0     <= '0;
            cy_p0     <= '0;
            FRAME_ERR <= 1'b0;
            for (int i = 0; i < OUT_W; i++)
                acc_p0[i] <= '0;
        end else if (PIX_VALID) begin
            if (restart)
                FRAME_ERR <= 1'b1;

            if (line_end) begin
                x_p0  <= '0;
                ex_p0 <= '0;
                cx_p0 <= '0;
                if (last_line) begin
                    y_p0  <= '0;
                    ey_p0 <= '0;
                    cy_p0 <= '0;
                end else begin
                    y_p0 <= y_e + YW'(1);
                    if (row_step) begin
                        ey_p0 <= ey_sum - EYW'(IN_H);
                        cy_p0 <= cy_e + CYW'(1);
                    end else begin
                        ey_p0 <= ey_sum;
                        cy_p0 <= cy_e;
                    end
                end
            end else begin
                x_p0  <= x_e + XW'(1);
                y_p0  <= y_e;
                ey_p0 <= ey_e;
                cy_p0 <= cy_e;
                if (col_step) begin
                    ex_p0 <= ex_sum - EXW'(IN_W);
                    cx_p0 <= cx_e + CXW'(1);
                end else begin
                    ex_p0 <= ex_sum;
                    cx_p0 <= cx_e;
                end
            end

            for (int i = 0; i < OUT_W; i++)
                acc_p0[i] <= band_end ? '0 : cnt_now[i];
        end
    end

    // Band shadow and emission FSM (stage p1)
    state_t           state_p1;
    logic [IW-1:0]    idx_p1;
    logic [IW-1:0]    idx_nxt;
    logic [OUT_W-1:0] shd_p1;
    logic             band_last_p1;

    assign idx_nxt = idx_p1 + IW'(1);

    // OUT_BIT is loaded with cell 0 directly; shd_p1 holds the remaining
    // cells, shifted down one per cycle. A new band end wins over the
    // final EMIT cycle so back-to-back bands need no dead cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_p1         <= IDLE;
            idx_p1           <= '0;
            shd_p1           <= '0;
            band_last_p1     <= 1'b0;
            OUT_VALID        <= 1'b0;
            OUT_BIT          <= 1'b0;
            OUT_LAST_IN_LINE <= 1'b0;
            OUT_LAST_PIX     <= 1'b0;
        end else if (band_end) begin
            state_p1         <= EMIT;
            idx_p1           <= '0;
            shd_p1           <= cmp >> 1;
            band_last_p1     <= last_line;
            OUT_VALID        <= 1'b1;
            OUT_BIT          <= cmp[0];
            OUT_LAST_IN_LINE <= (OUT_W == 1);
            OUT_LAST_PIX     <= (OUT_W == 1) && last_line;
        end else begin
            case (state_p1)
                EMIT: begin
                    if (idx_p1 == IW'(OUT_W - 1)) begin
                        state_p1         <= IDLE;
                        OUT_VALID        <= 1'b0;
                        OUT_BIT          <= 1'b0;
                        OUT_LAST_IN_LINE <= 1'b0;
                        OUT_LAST_PIX     <= 1'b0;
                    end else begin
                        idx_p1           <= idx_nxt;
                        shd_p1           <= shd_p1 >> 1;
                        OUT_BIT          <= shd_p1[0];
                        OUT_LAST_IN_LINE <= (idx_nxt == IW'(OUT_W - 1));
                        OUT_LAST_PIX     <= (idx_nxt == IW'(OUT_W - 1)) && band_last_p1;
                    end
                end
                default: begin
                    OUT_VALID        <= 1'b0;
                    OUT_BIT          <= 1'b0;
                    OUT_LAST_IN_LINE <= 1'b0;
                    OUT_LAST_PIX     <= 1'b0;
                end
            endcase
        end
    end

`ifdef IPU_RESIZE_POPCNT_OUT_EN
    logic [CNT_W-1:0] cnt_shd_p1 [OUT_W];

    // Count shadow follows the same load/shift pattern as shd_p1.
    always_ff @(posedge CLK) begin
        if (RST) begin
            CELL_COUNT <= '0;
            for (int i = 0; i < OUT_W; i++)
                cnt_shd_p1[i] <= '0;
        end else if (band_end) begin
            CELL_COUNT <= cnt_now[0];
            for (int i = 0; i < OUT_W - 1; i++)
                cnt_shd_p1[i] <= cnt_now[i+1];
            cnt_shd_p1[OUT_W-1] <= '0;
        end else if (state_p1 == EMIT) begin
            if (idx_p1 == IW'(OUT_W - 1)) begin
                CELL_COUNT <= '0;
            end else begin
                CELL_COUNT <= cnt_shd_p1[0];
                for (int i = 0; i < OUT_W - 1; i++)
                    cnt_shd_p1[i] <= cnt_shd_p1[i+1];
                cnt_shd_p1[OUT_W-1] <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ipu_resize_pool.sv
// Testbench for ipu_resize_pool with a small non-integer geometry
// (30x14 -> 12x5). Expected cells come from a floor-mapping reference
// model and are checked by an independent output monitor.

module tb_ipu_resize_pool;

    localparam int IN_W  = 30;
    localparam int IN_H  = 14;
    localparam int OUT_W = 12;
    localparam int OUT_H = 5;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             PIX_VALID = 1'b0;
    logic             PIX = 1'b0;
    logic             SOF = 1'b0;
    logic [CNT_W-1:0] THRESHOLD = '0;
    logic             OUT_VALID;
    logic             OUT_BIT;
    logic             OUT_LAST_IN_LINE;
    logic             OUT_LAST_PIX;
    logic             FRAME_ERR;
`ifdef IPU_RESIZE_POPCNT_OUT_EN
    logic [CNT_W-1:0] CELL_COUNT;
`endif

    ipu_resize_pool #(
        .IN_W(IN_W), .IN_H(IN_H), .OUT_W(OUT_W), .OUT_H(OUT_H), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .PIX_VALID(PIX_VALID),
        .PIX(PIX),
        .SOF(SOF),
        .THRESHOLD(THRESHOLD),
        .OUT_VALID(OUT_VALID),
        .OUT_BIT(OUT_BIT),
        .OUT_LAST_IN_LINE(OUT_LAST_IN_LINE),
        .OUT_LAST_PIX(OUT_LAST_PIX),
`ifdef IPU_RESIZE_POPCNT_OUT_EN
        .CELL_COUNT(CELL_COUNT),
`endif
        .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int b;
        int lil;
        int lp;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: plain pixel position and counts of the open band
    int   mx, my;
    int   mcnt [OUT_W];
    int   exp_err;
    int   img [IN_H][IN_W];

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        mx = 0;
        my = 0;
        exp_err = 0;
        for (int c = 0; c < OUT_W; c++) mcnt[c] = 0;
    endfunction

    function automatic void model_band(input int frame_last);
        exp_t e;
        for (int c = 0; c < OUT_W; c++) begin
            e.b   = (mcnt[c] >= int'(THRESHOLD)) ? 1 : 0;
            e.lil = (c == OUT_W - 1) ? 1 : 0;
            e.lp  = (c == OUT_W - 1 && frame_last != 0) ? 1 : 0;
            e.cnt = (mcnt[c] > CNT_MAX) ? CNT_MAX : mcnt[c];
            q.push_back(e);
            mcnt[c] = 0;
        end
    endfunction

    function automatic void model_pix(input int p, input int s);
        int r_now, r_next;
        if (s != 0 && (mx != 0 || my != 0)) begin
            mx = 0;
            my = 0;
            exp_err = 1;
            for (int c = 0; c < OUT_W; c++) mcnt[c] = 0;
        end
        mcnt[mx * OUT_W / IN_W] += p;
        if (mx == IN_W - 1) begin
            r_now  = my * OUT_H / IN_H;
            r_next = (my + 1) * OUT_H / IN_H;
            if (my == IN_H - 1 || r_next != r_now)
                model_band((my == IN_H - 1) ? 1 : 0);
            mx = 0;
            my = (my == IN_H - 1) ? 0 : my + 1;
        end else begin
            mx++;
        end
    endfunction

    // Entered and left at #1 after a rising edge.
    task automatic drive_pix(input int p, input int s, input int gaps);
        if (gaps != 0) begin
            while ($urandom_range(0, 1) == 1) begin
                @(posedge CLK); #1;
            end
        end
        PIX_VALID = 1'b1;
        PIX       = p[0];
        SOF       = s[0];
        model_pix(p, s);
        @(posedge CLK); #1;
        PIX_VALID = 1'b0;
        PIX       = 1'b0;
        SOF       = 1'b0;
    endtask

    task automatic send_frame(input int gaps, input int thr);
        THRESHOLD = CNT_W'(thr);
        for (int y = 0; y < IN_H; y++)
            for (int x = 0; x < IN_W; x++)
                drive_pix(img[y][x], (x == 0 && y == 0) ? 1 : 0, gaps);
    endtask

    task automatic fill_img(input int mode);
        for (int y = 0; y < IN_H; y++)
            for (int x = 0; x < IN_W; x++)
                case (mode)
                    0: img[y][x] = 0;
                    1: img[y][x] = 1;
                    default: img[y][x] = int'($urandom_range(0, 1));
                endcase
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || OUT_VALID) && t < 500) begin
            @(posedge CLK); #1;
            t++;
        end
        check("drain_queue_empty", q.size(), 0);
    endtask

    // Monitor: compares every presented cell and every burst length.
    initial begin
        int   run = 0;
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST) begin
                run = 0;
            end else if (OUT_VALID) begin
                run++;
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got OUT_BIT=%0d, expected no output (t=%0t)",
                             OUT_BIT, $time);
                end else begin
                    e = q.pop_front();
                    check("out_bit", int'(OUT_BIT), e.b);
                    check("out_last_in_line", int'(OUT_LAST_IN_LINE), e.lil);
                    check("out_last_pix", int'(OUT_LAST_PIX), e.lp);
`ifdef IPU_RESIZE_POPCNT_OUT_EN
                    check("cell_count", int'(CELL_COUNT), e.cnt);
`endif
                end
            end else if (run != 0) begin
                check("burst_len", run, OUT_W);
                run = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        model_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_out_valid", int'(OUT_VALID), 0);
        check("rst_out_bit", int'(OUT_BIT), 0);
        check("rst_last_in_line", int'(OUT_LAST_IN_LINE), 0);
        check("rst_last_pix", int'(OUT_LAST_PIX), 0);
        check("rst_frame_err", int'(FRAME_ERR), 0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // Back-to-back frames of assorted content and thresholds
        fill_img(1); send_frame(0, 6);
        fill_img(2); send_frame(0, 3);
        send_frame(1, 3);
        fill_img(0); img[IN_H-1][IN_W-1] = 1; send_frame(1, 1);
        fill_img(2); send_frame(1, 0);
        fill_img(1); send_frame(0, 9);
        drain();
        check("frame_err_clean", int'(FRAME_ERR), 0);

        // SOF in the middle of a frame restarts it from that pixel
        fill_img(2);
        THRESHOLD = CNT_W'(4);
        for (int k = 0; k < 200; k++)
            drive_pix(img[k / IN_W][k % IN_W], (k == 0) ? 1 : 0, 0);
        check("frame_err_before_sof", int'(FRAME_ERR), 0);
        fill_img(2);
        send_frame(1, 4);
        drain();
        check("frame_err_after_sof", int'(FRAME_ERR), exp_err);

        // Reset in the middle of an emission burst
        fill_img(2);
        THRESHOLD = CNT_W'(2);
        for (int k = 0; k < 3 * IN_W; k++)
            drive_pix(img[k / IN_W][k % IN_W], (k == 0) ? 1 : 0, 0);
        t = 0;
        while (!OUT_VALID && t < 50) begin
            @(posedge CLK); #1;
            t++;
        end
        check("emit_started", int'(OUT_VALID), 1);
        repeat (10) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        check("valid_after_rst", int'(OUT_VALID), 0);
        q.delete();
        model_reset();
        @(posedge CLK); #1;
        RST = 1'b0;
        check("frame_err_cleared", int'(FRAME_ERR), 0);
        fill_img(2);
        send_frame(1, 5);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
